// File: rtl/des_key_sched_seq.sv
// DES round-key scheduler: loads one 64-bit key and streams K1..K16 (encrypt)
// or K16..K1 (decrypt), one 48-bit subkey per accepted output beat.

module des_pc2 (
   input  logic [55:0] cd_i,
   output logic [47:0] subkey_o
);
   // Table entries are 1-based DES bit numbers, bit 1 being the MSB of cd_i.
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   logic unused_cd;
   assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                        cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

   always_comb begin
      subkey_o = '0;
      for (int i = 0; i < 48; i++) begin
         subkey_o[47-i] = cd_i[56-PC2[i]];
      end
   end
endmodule

// state | meaning
// IDLE  | waiting for a key; in_ready high
// RUN   | presenting subkey step_q of the current sequence; out_valid high
module des_key_sched_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] key,
   input  logic        decrypt,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [47:0] subkey,
   output logic [3:0]  sub_idx,
   output logic        sub_last,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        abort
);
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t      state_q;
   logic [55:0] cd_q;
   logic [55:0] cd_d;
   logic [55:0] pc1_w;
   logic [3:0]  step_q;
   logic        dir_q;
   logic        single_w;

   logic unused_parity;
   assign unused_parity = ^{key[56], key[48], key[40], key[32],
                            key[24], key[16], key[8],  key[0]};

   function automatic logic [27:0] rot28(input logic [27:0] v, input logic left,
                                         input logic one);
      logic [27:0] r;
      if (left) r = one ? {v[26:0], v[27]}    : {v[25:0], v[27:26]};
      else      r = one ? {v[0],    v[27:1]}  : {v[1:0],  v[27:2]};
      return r;
   endfunction

   always_comb begin
      pc1_w = '0;
      for (int i = 0; i < 56; i++) begin
         pc1_w[55-i] = key[64-PC1[i]];
      end
   end

   // Single-bit shifts land between beats 0/1, 7/8 and 14/15 in either direction.
   assign single_w = (step_q == 4'd0) || (step_q == 4'd7) || (step_q == 4'd14);
   assign cd_d     = {rot28(cd_q[55:28], !dir_q, single_w),
                      rot28(cd_q[27:0],  !dir_q, single_w)};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cd_q    <= '0;
         step_q  <= '0;
         dir_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  cd_q    <= decrypt ? pc1_w
                                     : {rot28(pc1_w[55:28], 1'b1, 1'b1),
                                        rot28(pc1_w[27:0],  1'b1, 1'b1)};
                  dir_q   <= decrypt;
                  step_q  <= '0;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  step_q  <= '0;
               end else if (out_ready) begin
                  if (step_q == 4'd15) begin
                     state_q <= ST_IDLE;
                     step_q  <= '0;
                  end else begin
                     step_q <= step_q + 4'd1;
                     cd_q   <= cd_d;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_RUN);
   assign sub_idx   = dir_q ? (4'd15 - step_q) : step_q;
   assign sub_last  = (step_q == 4'd15);

   des_pc2 u_pc2 (
      .cd_i     (cd_q),
      .subkey_o (subkey)
   );
endmodule

// File: doc/des_key_sched_seq.md
Name: des_key_sched_seq

Overview:
- Sequential DES round-key scheduler.
- Accepts one 64-bit key and streams the 16 48-bit round subkeys, one per accepted output beat.
- Order is selectable per key:
  - encrypt order: K1..K16, left rotations;
  - decrypt order: K16..K1, right rotations.
- Sits between the key register and a one-round-per-cycle DES datapath. Lets that datapath decrypt without a fully unrolled key array.
- Reuses the existing PC2 combinational module. PC1 is implemented internally.

Parameters:
- None. DES widths are fixed.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- key  in  64  DES key, bit 0 is MSB (big-endian numbering [0:63]); parity bits 7,15,...,63 are ignored.
- decrypt  in  1  sampled with key: 0 = emit K1..K16, 1 = emit K16..K1.
- in_valid  in  1  key/decrypt valid.
- in_ready  out  1  block can accept a key.
- subkey  out  48  current round subkey, [0:47].
- sub_idx  out  4  subkey number minus 1 (0 means K1, 15 means K16).
- sub_last  out  1  current beat is the 16th of the sequence.
- out_valid  out  1  subkey/sub_idx/sub_last valid.
- out_ready  in  1  consumer accepts the beat.
- abort  in  1  synchronous abandon of the current sequence.

Behaviour:
- State machine:
  - States are IDLE and RUN.
  - in_ready = (state==IDLE). out_valid = (state==RUN).
- Reset (rst_n low, asynchronous):
  - state=IDLE, CD register=0, step counter=0, dir=0.
  - Outputs: out_valid=0, in_ready=1 once released, subkey=PC2(0)=0, sub_idx=0, sub_last=0.
- Load (IDLE, in_valid=1):
  - CD <= PC1(key) as {C0,D0}, 28+28 bits, FIPS 46-3 PC1 table. dir <= decrypt. step <= 0.
  - Encrypt load (decrypt=0): CD is additionally rotated left by 1, so CD holds C1D1 when loading completes.
  - Decrypt load (decrypt=1): CD holds C0D0, which equals C16D16 since 28 total shifts is a full rotation.
  - state <= RUN. The first beat is valid the cycle after the load handshake (1-cycle latency).
- RUN outputs:
  - subkey = PC2(CD), combinational from the register.
  - sub_idx = dir ? 15-step : step.
  - sub_last = (step==15).
  - All outputs hold stable while out_ready=0. There is no bubble between beats when out_ready stays high.
- Advance (out_valid && out_ready, step<15):
  - step <= step+1.
  - Encrypt: C,D each rotate left by 1 if the new subkey number is 2, 9 or 16, else by 2.
  - Decrypt: C,D each rotate right by s(next):
    - next step 1, 8 or 15 uses 1;
    - every other step uses 2;
    - full schedule from the first decrypt beat: 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Completion:
  - An accepted beat with step==15 returns state to IDLE. out_valid=0 and in_ready=1 the next cycle.
  - A new key is accepted in IDLE only, so at least one idle cycle separates sequences.
- Abort:
  - abort=1 in RUN forces IDLE next cycle with step=0, regardless of out_ready.
  - abort in IDLE is ignored.
  - abort has priority over an advance in the same cycle. The beat counts as not delivered.
- Mid-sequence reset: immediate return to the reset values; the partial stream is discarded.
- in_valid while in RUN is ignored; key is not sampled.

Test Plan:
- Encrypt order:
  - Stimulus: key=0x133457799BBCDFF1, decrypt=0, out_ready=1.
  - Response: 16 consecutive beats. Beat 0 has subkey=0x1B02EFFC7072, sub_idx=0. Beat 15 has subkey=0xCB3D8B0E17F5, sub_idx=15, sub_last=1. IDLE follows.
- Decrypt order:
  - Stimulus: same key, decrypt=1.
  - Response: beat 0 is 0xCB3D8B0E17F5 with sub_idx=15. Beat 15 is 0x1B02EFFC7072 with sub_idx=0 and sub_last=1. Every beat equals the reverse of the encrypt run, cross-checked against the 16-output combinational schedule model.
- Backpressure:
  - Stimulus: random out_ready (~50%).
  - Response: subkey and sub_idx hold while stalled, no beat is skipped or duplicated, and the sequence matches the unstalled run.
- Abort:
  - Stimulus: assert abort at beat 5 with out_ready=1.
  - Response: out_valid=0 next cycle, in_ready=1. A fresh decrypt load then produces a correct full sequence.
- Async reset mid-run:
  - Stimulus: drop rst_n at beat 9, between clock edges.
  - Response: out_valid falls immediately, sub_idx=0. After release, a new key produces a correct sequence.
- Parity independence:
  - Stimulus: key=0x133457799BBCDFF1 vs 0x123456789ABCDEF0 with parity bits flipped only.
  - Response: identical subkey streams for both directions.
